uart_tx_mmio: RTL

Memory-mapped UART transmitter on the shared data bus, alongside data memory and downstream of the CPU core's load/store path. It decodes core bus cycles in its address window and queues written bytes in a small FIFO. Bytes are serialised 8N1, LSB first, on a single tx pin. It exposes status/control registers and a level interrupt.

---
 rtl/uart_tx_mmio_if.sv | 24 ++
 rtl/uart_tx_mmio.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio_if.sv
// Core data-bus bundle for the UART transmitter window.
//   data_bus_addr : byte address from the core
//   data_bus_mode : 00 idle, 01 read, 10 write, 11 idle
//   data_bus_data : shared data lines; resolved here from the core write
//                   data and the slave read data, high-Z otherwise
//   wr_data       : value the core puts on the lines during a write
//   rd_data/rd_oe : slave read value and its drive enable
interface uart_tx_mmio_if;
  logic [31:0] data_bus_addr;
  logic [1:0]  data_bus_mode;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_oe;
  wire  [31:0] data_bus_data;

  // The slave only drives on a decoded read, the core only on a write.
  assign data_bus_data = rd_oe                     ? rd_data :
                         (data_bus_mode == 2'b10)  ? wr_data : 32'bz;

  modport master (output data_bus_addr, data_bus_mode, wr_data,
                  input  rd_data, rd_oe, data_bus_data);
  modport slave  (input  data_bus_addr, data_bus_mode, data_bus_data,
                  output rd_data, rd_oe);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : core data bus (slave side)
//   tx    : serial line, idle high
//   irq   : level interrupt, FIFO drained and line idle (registered)
// Registers: 0x0 TXDATA (W), 0x4 STATUS (R, W1C bit3), 0x8 CTRL (RW), 0xC reserved.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [4:0]      count;
  logic            ovf, tx_en, irq_en, irq_q;
  logic            hit, wr, rd, push_req, push, pop, full, empty, busy;
  logic [1:0]      off;
  logic [31:0]     wdata;

  // ---------------- bus decode ----------------
  assign hit   = (bus.data_bus_addr[31:4] == BASE_ADDR[31:4]);
  assign off   = bus.data_bus_addr[3:2];
  assign wr    = hit && (bus.data_bus_mode == 2'b10);
  // Bus stays released while in reset.
  assign rd    = hit && (bus.data_bus_mode == 2'b01) && reset;
  assign wdata = bus.data_bus_data;

  assign full     = (count == 5'(FIFO_DEPTH));
  assign empty    = (count == 5'd0);
  assign busy     = (state_q != S_IDLE);
  assign push_req = wr && (off == 2'd0);
  assign push     = push_req && !full;

  assign bus.rd_oe = rd;
  always_comb begin
    bus.rd_data = '0;
    case (off)
      2'd1:    bus.rd_data = {23'b0, count, ovf, empty, full, busy};
      2'd2:    bus.rd_data = {30'b0, irq_en, tx_en};
      default: bus.rd_data = '0;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_en  <= 1'b0;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && off == 2'd2) begin
        tx_en  <= wdata[0];
        irq_en <= wdata[1];
      end
      if (push_req && full)
        ovf <= 1'b1;
      else if (wr && off == 2'd1 && wdata[3])
        ovf <= 1'b0;
      irq_q <= irq_en && empty && !busy;
    end
  end
  assign irq = irq_q;

  // ---------------- FIFO ----------------
  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- serialiser FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // pop uses the pre-edge empty flag, so a byte pushed into an empty
  // FIFO is first seen by the FSM one edge later.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_en && !empty) begin
          pop     = 1'b1;
          shift_d = mem[rptr];
          state_d = S_START;
          baud_d  = BAUD_MAX;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          state_d = S_DATA;
          baud_d  = BAUD_MAX;
          bit_d   = 3'd0;
        end else baud_d = baud_q - 1'b1;
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_MAX;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else baud_d = baud_q - 1'b1;
      end
      S_STOP: begin
        if (baud_q == '0) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end else baud_d = baud_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded straight from state so reset forces the line high at once.
  assign tx = (state_q == S_START) ? 1'b0 :
              (state_q == S_DATA)  ? shift_q[0] : 1'b1;
endmodule
